// File: rtl/fifo_cdc.sv
// FIFO with Gray-coded pointers and 2-flop pointer synchronizers, single clock for now.
// Pop data registered (1 edge); remote-side flag updates lag 2 edges, local-side flags update at once.
module fifo_cdc #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PW         = ADDR_WIDTH + 1;
  // Full when the write pointer is exactly one lap ahead: in Gray code that flips the top two bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_bin, wptr_gray, wptr_bin_next;
  logic [PW-1:0] rptr_bin, rptr_gray, rptr_bin_next;
  logic [PW-1:0] wgray_sync1, wgray_sync2;
  logic [PW-1:0] rgray_sync1, rgray_sync2;
  logic          push, pop;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign fifo_empty    = (rptr_gray == wgray_sync2);
  assign fifo_full     = (wptr_gray == (rgray_sync2 ^ FULL_MASK));
  assign push          = write_en & ~fifo_full;
  assign pop           = read_en & ~fifo_empty;
  assign wptr_bin_next = wptr_bin + PW'(1);
  assign rptr_bin_next = rptr_bin + PW'(1);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wptr_bin[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  // Write side: pointer plus synchronized copy of the read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      rgray_sync1 <= '0;
      rgray_sync2 <= '0;
    end else begin
      rgray_sync1 <= rptr_gray;
      rgray_sync2 <= rgray_sync1;
      if (push) begin
        wptr_bin  <= wptr_bin_next;
        wptr_gray <= bin2gray(wptr_bin_next);
      end
    end
  end

  // Read side: pointer, output register and synchronized copy of the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_bin    <= '0;
      rptr_gray   <= '0;
      wgray_sync1 <= '0;
      wgray_sync2 <= '0;
      data_out    <= '0;
    end else begin
      wgray_sync1 <= wptr_gray;
      wgray_sync2 <= wgray_sync1;
      if (pop) begin
        data_out  <= mem[rptr_bin[ADDR_WIDTH-1:0]];
        rptr_bin  <= rptr_bin_next;
        rptr_gray <= bin2gray(rptr_bin_next);
      end
    end
  end

endmodule

// File: tb/tb_fifo_cdc.sv
// Directed bench for fifo_cdc: flag latency, ordering, full/empty boundaries, wrap and reset.
module tb_fifo_cdc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_out;
  logic       fifo_empty;
  logic       fifo_full;

  int tests  = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  fifo_cdc #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .write_en   (write_en),
    .read_en    (read_en),
    .data_out   (data_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check("reset_empty", 32'(fifo_empty), 32'd1);
    check("reset_full", 32'(fifo_full), 32'd0);
    check("reset_dout", 32'(data_out), 32'h00);

    // Three pushes: empty clears two edges after the first one.
    write_en = 1'b1; data_in = 8'hAA; step();
    check("push1_empty", 32'(fifo_empty), 32'd1);
    check("push1_full", 32'(fifo_full), 32'd0);
    data_in = 8'hBB; step();
    check("push2_empty", 32'(fifo_empty), 32'd1);
    data_in = 8'hCC; step();
    check("push3_empty", 32'(fifo_empty), 32'd0);
    check("push3_full", 32'(fifo_full), 32'd0);
    write_en = 1'b0;

    read_en = 1'b1; step();
    check("pop1_data", 32'(data_out), 32'hAA);
    check("pop1_empty", 32'(fifo_empty), 32'd0);
    step();
    check("pop2_data", 32'(data_out), 32'hBB);
    step();
    check("pop3_data", 32'(data_out), 32'hCC);
    check("pop3_empty", 32'(fifo_empty), 32'd1);

    // Pop on empty leaves data_out alone.
    step();
    check("underflow_data", 32'(data_out), 32'hCC);
    check("underflow_empty", 32'(fifo_empty), 32'd1);
    read_en = 1'b0;
    step();
    step();

    // Fill to full; fullness after exactly 16 also proves the read pointer did not move on underflow.
    write_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(i);
      step();
      if (i == 14) check("fill15_full", 32'(fifo_full), 32'd0);
    end
    check("fill16_full", 32'(fifo_full), 32'd1);
    data_in = 8'hFF; step();
    check("overflow_full", 32'(fifo_full), 32'd1);
    write_en = 1'b0;

    read_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("drain_data%0d", i), 32'(data_out), 32'(i));
      if (i < 2)  check($sformatf("drain_full%0d", i), 32'(fifo_full), 32'd1);
      if (i == 2) check("drain_full_clear", 32'(fifo_full), 32'd0);
    end
    check("drain_empty", 32'(fifo_empty), 32'd1);
    step();
    check("overflow_dropped", 32'(data_out), 32'h0F);
    read_en = 1'b0;

    // Prime four words, let flags settle, then mixed traffic that wraps the pointers.
    write_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'(8'h30 + i);
      q.push_back(data_in);
      step();
    end
    write_en = 1'b0;
    step(); step(); step();
    check("prime_empty", 32'(fifo_empty), 32'd0);

    for (int i = 0; i < 40; i++) begin
      write_en = (i % 4 != 3);
      read_en  = (i % 4 != 1);
      data_in  = 8'(8'h40 + i);
      exp_d = data_out;
      if (read_en) exp_d = q.pop_front();
      if (write_en) q.push_back(data_in);
      step();
      check($sformatf("wrap_data%0d", i), 32'(data_out), 32'(exp_d));
      check($sformatf("wrap_empty%0d", i), 32'(fifo_empty), 32'd0);
      check($sformatf("wrap_full%0d", i), 32'(fifo_full), 32'd0);
    end
    read_en = 1'b0;

    // Top up to five stored words, then reset with a push and pop also requested.
    write_en = 1'b1; data_in = 8'h77; q.push_back(data_in); step();
    check("pre_reset_count", 32'(q.size()), 32'd5);
    rst = 1'b1; write_en = 1'b1; read_en = 1'b1; data_in = 8'h99;
    step();
    rst = 1'b0; write_en = 1'b0;
    check("rst_dout", 32'(data_out), 32'h00);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_dout%0d", i), 32'(data_out), 32'h00);
      check($sformatf("post_rst_empty%0d", i), 32'(fifo_empty), 32'd1);
    end
    read_en = 1'b0;

    write_en = 1'b1; data_in = 8'h5A; step();
    write_en = 1'b0; step(); step();
    read_en = 1'b1; step();
    check("post_rst_push_pop", 32'(data_out), 32'h5A);
    check("post_rst_final_empty", 32'(fifo_empty), 32'd1);
    read_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/fifo_cdc.md
FIFO_CDC -- requirements
Module: fifo_cdc

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, at least 2; ADDR_WIDTH = log2(DEPTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 data_in  input  DATA_WIDTH  word to push.
REQ-007 write_en  input  1  push request, sampled each rising edge.
REQ-008 read_en  input  1  pop request, sampled each rising edge.
REQ-009 data_out  output  DATA_WIDTH  registered popped word.
REQ-010 fifo_empty  output  1  no word available to the read side.
REQ-011 fifo_full  output  1  no free entry visible to the write side.

Function
REQ-012 Storage SHALL be a DEPTH x DATA_WIDTH array, with write and read pointers each ADDR_WIDTH+1 bits wide, binary-counted and also held in Gray-code registers.
REQ-013 Each Gray pointer SHALL pass through a 2-flop synchronizer into the opposite side (wptr -> read side, rptr -> write side), so the structure can later be split across clock domains.
REQ-014 Push: on an edge with write_en=1 and fifo_full=0, mem[wptr[ADDR_WIDTH-1:0]] <= data_in and wptr increments; with fifo_full=1 the push is dropped with no state change.
REQ-015 Pop: on an edge with read_en=1 and fifo_empty=0, data_out <= mem[rptr[ADDR_WIDTH-1:0]] and rptr increments; a pop is visible on data_out one edge after the request edge.
REQ-016 Pop with fifo_empty=1 is ignored; data_out holds its previous value.
REQ-017 data_out SHALL hold its value on every edge without an accepted pop.
REQ-018 fifo_empty SHALL be combinational: (rptr_gray == synchronized wptr_gray).
REQ-019 fifo_full SHALL be combinational: wptr_gray equals synchronized rptr_gray with its two MSBs inverted and the remaining bits equal.
REQ-020 Flag latency: a push at edge N deasserts fifo_empty after edge N+2; a pop at edge N deasserts fifo_full after edge N+2; flags are conservative (may be stale-asserted, never stale-deasserted).
REQ-021 The local side updates its own flag immediately: fifo_empty asserts right after the pop that consumes the last visible word, and fifo_full asserts right after the push that fills the last visible free entry.
REQ-022 Pointers SHALL wrap modulo 2*DEPTH; the extra MSB distinguishes full from empty across wrap-around.
REQ-023 A simultaneous accepted push and pop in one edge SHALL both take effect; occupancy is unchanged.
REQ-024 Memory contents need no reset.

Reset
REQ-025 While rst=1 at an edge: both pointers (binary and Gray) and all synchronizer flops clear to 0, and data_out clears to 0.
REQ-026 After reset: fifo_empty=1 and fifo_full=0.
REQ-027 Reset mid-operation discards all stored words and overrides any push or pop in the same edge.

Verification
REQ-028 Reset, then push 0xAA, 0xBB, 0xCC on 3 consecutive edges -> fifo_empty stays 1 until 2 edges after the 0xAA push, then 0; fifo_full stays 0.
REQ-029 Then pop 3 times -> data_out = 0xAA, 0xBB, 0xCC on successive edges; fifo_empty = 1 right after the third pop.
REQ-030 Pop while empty -> data_out keeps 0xCC and the pointers do not move.
REQ-031 Push 16 words 0x00..0x0F -> fifo_full = 1 after the 16th; a 17th push (0xFF) is dropped; 16 pops return 0x00..0x0F in order; fifo_full drops 2 edges after the first pop.
REQ-032 Run 40 push/pop cycles including simultaneous push+pop to cross pointer wrap -> data order preserved, no spurious full or empty flags.
REQ-033 Assert rst with 5 words stored -> next edge: data_out = 0, fifo_empty = 1, fifo_full = 0, and no old data can be popped afterward.
